// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: byte command decoder for a 16 x 8 register space.
// Read command  : 0000_aaaa       -> one response byte (register or status_i at 15)
// Write command : 1000_aaaa, data -> ACK_BYTE
// Optional feature macro: UART_CMD_NAK_EN (answer invalid commands with NAK_BYTE).
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_CMD  | idle, waiting for a command byte
// S_DATA | write command accepted, waiting for its data byte
// S_RESP | response byte presented on tx_data/tx_ready until tx_ack
// S_ERR  | uart framing error seen, frozen until sys_rst

module uart_cmd_responder #(
  parameter logic [7:0] ACK_BYTE   = 8'h06,
  parameter logic [7:0] NAK_BYTE   = 8'h15,
  parameter logic [7:0] CTRL_RESET = 8'h00
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_ack,
  input  logic       rx_error,
  output logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       tx_ack,
  input  logic [7:0] status_i,
  output logic [7:0] ctrl_o,
  output logic       err_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    S_CMD  = 2'd0,
    S_DATA = 2'd1,
    S_RESP = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] addr;
  logic [7:0] regs [15];
  logic [7:0] read_value;
  logic       cmd_invalid;
  logic       cmd_write;

`ifndef UART_CMD_NAK_EN
  // Invalid commands are silently dropped, so the NAK byte has no consumer.
  logic nak_unused;
  assign nak_unused = ^NAK_BYTE;
`endif

  assign cmd_invalid = (rx_data[6:4] != 3'b000);
  assign cmd_write   = rx_data[7];
  assign ctrl_o      = regs[0];
  assign busy_o      = (state != S_CMD);

  // A byte is consumed only where the FSM below acts on it; error and reset win.
  always_comb begin
    rx_ack = rx_ready && ((state == S_CMD) || (state == S_DATA)) && !rx_error && !sys_rst;
  end

  // Read mux; address 15 is the live status input, sampled when the command is consumed.
  always_comb begin
    read_value = 8'h00;
    if (rx_data[3:0] == 4'hF) read_value = status_i;
    else                      read_value = regs[rx_data[3:0]];
  end

  // Command FSM with registered response and error outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= S_CMD;
      addr     <= 4'h0;
      tx_data  <= 8'h00;
      tx_ready <= 1'b0;
      err_o    <= 1'b0;
      for (int i = 1; i < 15; i++) regs[i] <= 8'h00;
      regs[0]  <= CTRL_RESET;
    end else if (rx_error) begin
      state    <= S_ERR;
      err_o    <= 1'b1;
      tx_ready <= 1'b0;
    end else begin
      case (state)
        S_CMD: begin
          if (rx_ready) begin
            if (cmd_invalid) begin
`ifdef UART_CMD_NAK_EN
              tx_data  <= NAK_BYTE;
              tx_ready <= 1'b1;
              state    <= S_RESP;
`endif
            end else if (cmd_write) begin
              addr  <= rx_data[3:0];
              state <= S_DATA;
            end else begin
              tx_data  <= read_value;
              tx_ready <= 1'b1;
              state    <= S_RESP;
            end
          end
        end
        S_DATA: begin
          if (rx_ready) begin
            // Writes to address 15 are accepted and acknowledged but go nowhere.
            if (addr != 4'hF) regs[addr] <= rx_data;
            tx_data  <= ACK_BYTE;
            tx_ready <= 1'b1;
            state    <= S_RESP;
          end
        end
        S_RESP: begin
          if (tx_ack) begin
            tx_ready <= 1'b0;
            state    <= S_CMD;
          end
        end
        default: begin
          state <= S_ERR;
        end
      endcase
    end
  end

endmodule
